// File: rtl/branch_history_ctrl.sv
// Per-PC branch history table of 2-bit saturating counters with an init sweep controller.
// Optional BHT_PERF_COUNTERS_EN adds branch and mispredict event counters.
module branch_history_ctrl #(
  parameter int unsigned IDX_BITS = 6,
  parameter logic [1:0]  INIT_CNT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic        lookup_valid,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic        update_mispredict,
  input  logic        clear_req,
  output logic        ready
`ifdef BHT_PERF_COUNTERS_EN
  ,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
`endif
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  typedef logic [IDX_BITS-1:0] idx_t;

  typedef enum logic {
    StInit,
    StReady
  } state_e;

  state_e     state_q, state_d;
  idx_t       sweep_idx_q, sweep_idx_d;

  logic [1:0] table_q [Entries];

  logic       upd_valid_q;
  idx_t       upd_idx_q;
  logic       upd_taken_q;

  logic       is_ready;
  logic       upd_accept;
  idx_t       lookup_idx;
  idx_t       update_idx;

  logic       tbl_we;
  idx_t       tbl_waddr;
  logic [1:0] tbl_wdata;
  logic [1:0] rmw_old;
  logic [1:0] rmw_new;

  assign is_ready   = (state_q == StReady);
  assign lookup_idx = lookup_pc[IDX_BITS+1:2];
  assign update_idx = update_pc[IDX_BITS+1:2];
  // Clear has priority over a same-cycle update.
  assign upd_accept = is_ready & update_en & ~clear_req;

  // Sweep / ready controller.
  always_comb begin
    state_d     = state_q;
    sweep_idx_d = sweep_idx_q;
    if (clear_req) begin
      state_d     = StInit;
      sweep_idx_d = '0;
    end else begin
      unique case (state_q)
        StInit: begin
          sweep_idx_d = sweep_idx_q + 1'b1;
          if (&sweep_idx_q) begin
            state_d = StReady;
          end
        end
        StReady: begin
          state_d = StReady;
        end
        default: begin
          state_d     = StInit;
          sweep_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StInit;
      sweep_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_idx_q <= sweep_idx_d;
    end
  end

  // Update pipeline register; dropped entirely on clear or while sweeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
      upd_taken_q <= 1'b0;
    end else begin
      upd_valid_q <= upd_accept;
      if (upd_accept) begin
        upd_idx_q   <= update_idx;
        upd_taken_q <= update_taken;
      end
    end
  end

  // The previous RMW lands at the edge before this read, so back-to-back updates to one
  // index see the in-flight result directly from the array.
  assign rmw_old = table_q[upd_idx_q];

  always_comb begin
    rmw_new = rmw_old;
    if (upd_taken_q) begin
      if (rmw_old != 2'b11) begin
        rmw_new = rmw_old + 2'd1;
      end
    end else begin
      if (rmw_old != 2'b00) begin
        rmw_new = rmw_old - 2'd1;
      end
    end
  end

  // Single write port shared by the sweep and the update RMW.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = '0;
    tbl_wdata = INIT_CNT;
    if (state_q == StInit) begin
      tbl_we    = 1'b1;
      tbl_waddr = sweep_idx_q;
      tbl_wdata = INIT_CNT;
    end else if (upd_valid_q && !clear_req) begin
      tbl_we    = 1'b1;
      tbl_waddr = upd_idx_q;
      tbl_wdata = rmw_new;
    end
  end

  // Counter storage has no reset; the sweep initialises it.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      table_q[tbl_waddr] <= tbl_wdata;
    end
  end

  assign ready        = is_ready;
  assign lookup_valid = is_ready;
  assign lookup_taken = is_ready & table_q[lookup_idx][1];

`ifdef BHT_PERF_COUNTERS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispredict_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (clear_req) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (upd_accept) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (update_mispredict) begin
        mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
      end
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
`else
  logic unused_mispredict;
  assign unused_mispredict = update_mispredict;
`endif

  // PC bits outside the index field are intentionally ignored (no tags).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS+2], lookup_pc[1:0],
                            update_pc[31:IDX_BITS+2], update_pc[1:0]};

endmodule

// File: tb/tb_branch_history_ctrl.sv
// Scoreboard bench for branch_history_ctrl against a table-of-integers reference model.
module tb_branch_history_ctrl;

  localparam int Entries = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        lookup_taken;
  logic        lookup_valid;
  logic        update_en = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic        update_mispredict = 1'b0;
  logic        clear_req = 1'b0;
  logic        ready;
`ifdef BHT_PERF_COUNTERS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
`endif

  always #5 clk = ~clk;

  branch_history_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_pc         (lookup_pc),
    .lookup_taken      (lookup_taken),
    .lookup_valid      (lookup_valid),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_mispredict (update_mispredict),
    .clear_req         (clear_req),
    .ready             (ready)
`ifdef BHT_PERF_COUNTERS_EN
    ,
    .branch_cnt        (branch_cnt),
    .mispredict_cnt    (mispredict_cnt)
`endif
  );

  typedef struct {
    bit          rdy;
    bit          tkn;
    int unsigned bcnt;
    int unsigned mcnt;
    string       name;
  } exp_t;

  typedef struct {
    int idx;
    bit tkn;
    int due;
  } pend_t;

  exp_t  exp_q[$];
  pend_t pend_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state
  int          m_tbl[Entries];
  bit          m_ready;
  int          m_init_left;
  int unsigned m_bcnt;
  int unsigned m_mcnt;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc / 4) % Entries);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_wipe();
    pend_q.delete();
    for (int i = 0; i < Entries; i++) m_tbl[i] = 1;
    m_ready     = 1'b0;
    m_init_left = Entries;
    m_bcnt      = 0;
    m_mcnt      = 0;
  endtask

  task automatic model_edge(input bit ue, input logic [31:0] upc, input bit ut, input bit um,
                            input bit clr, input bit r);
    pend_t p;
    if (r || clr) begin
      model_wipe();
      return;
    end
    for (int i = 0; i < pend_q.size(); i++) pend_q[i].due--;
    while (pend_q.size() > 0 && pend_q[0].due <= 0) begin
      p = pend_q.pop_front();
      if (p.tkn) m_tbl[p.idx] = (m_tbl[p.idx] < 3) ? m_tbl[p.idx] + 1 : 3;
      else       m_tbl[p.idx] = (m_tbl[p.idx] > 0) ? m_tbl[p.idx] - 1 : 0;
    end
    if (m_ready && ue) begin
      p.idx = midx(upc);
      p.tkn = ut;
      p.due = 1;
      pend_q.push_back(p);
      m_bcnt++;
      if (um) m_mcnt++;
    end
    if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) m_ready = 1'b1;
    end
  endtask

  task automatic step(input logic [31:0] lpc, input bit ue, input logic [31:0] upc, input bit ut,
                      input bit um, input bit clr, input bit r, input string nm);
    exp_t e;
    lookup_pc         = lpc;
    update_en         = ue;
    update_pc         = upc;
    update_taken      = ut;
    update_mispredict = um;
    clear_req         = clr;
    rst               = r;
    e.rdy  = !r && m_ready;
    e.tkn  = e.rdy && (m_tbl[midx(lpc)] >= 2);
    e.bcnt = r ? 0 : m_bcnt;
    e.mcnt = r ? 0 : m_mcnt;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    model_edge(ue, upc, ut, um, clr, r);
  endtask

  task automatic idle(input logic [31:0] lpc, input string nm);
    step(lpc, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".ready"}, {31'd0, ready}, {31'd0, e.rdy});
      chk({e.name, ".lookup_valid"}, {31'd0, lookup_valid}, {31'd0, e.rdy});
      chk({e.name, ".lookup_taken"}, {31'd0, lookup_taken}, {31'd0, e.tkn});
`ifdef BHT_PERF_COUNTERS_EN
      chk({e.name, ".branch_cnt"}, branch_cnt, e.bcnt);
      chk({e.name, ".mispredict_cnt"}, mispredict_cnt, e.mcnt);
`endif
    end
  end

  initial begin
    model_wipe();
    @(posedge clk);
    #1;

    // Reset and full sweep, with an update during INIT that must be dropped.
    step(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    step(32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    for (int i = 0; i < 66; i++)
      step(32'h40, i == 10, 32'h40, 1'b1, 1'b1, 1'b0, 1'b0, "init_sweep");

    // Saturate up.
    for (int i = 0; i < 4; i++)
      step(32'h100, 1'b1, 32'h100, 1'b1, i == 1, 1'b0, 1'b0, "sat_up");
    for (int i = 0; i < 3; i++) idle(32'h100, "sat_up_hold");

    // Walk down with hysteresis and saturate at zero.
    for (int i = 0; i < 5; i++) begin
      step(32'h100, 1'b1, 32'h100, 1'b0, i == 0, 1'b0, 1'b0, "sat_down");
      idle(32'h100, "sat_down_obs");
    end
    for (int i = 0; i < 2; i++) idle(32'h100, "sat_down_hold");

    // Aliasing.
    step(32'h8, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, "alias_upd");
    step(32'h8, 1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 1'b0, "alias_upd");
    idle(32'h108, "alias_wait");
    idle(32'h108, "alias_wait");
    idle(32'h108, "alias_108");
    idle(32'h0C, "alias_0c");

    // Clear with an update in flight and a simultaneous update, then restart mid-sweep.
    step(32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, "clr_pre");
    step(32'h200, 1'b1, 32'h300, 1'b1, 1'b1, 1'b1, 1'b0, "clr_pulse");
    for (int i = 0; i < 30; i++) idle(32'h200, "clr_sweep");
    step(32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "clr_restart");
    for (int i = 0; i < 66; i++) idle($urandom_range(0, 255) << 2, "clr_sweep2");

    // Reset in the middle of a sweep.
    step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "rst_mid_clr");
    for (int i = 0; i < 20; i++) idle(32'h0, "rst_mid_sweep");
    step(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, "rst_mid");
    for (int i = 0; i < 66; i++) idle($urandom_range(0, 255) << 2, "rst_sweep");

    // Random traffic over a small aliased PC pool.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] upc;
      logic [31:0] lpc;
      upc = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8);
      lpc = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8);
      step(lpc, $urandom_range(0, 9) < 7, upc, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, $urandom_range(0, 249) == 0, 1'b0, "random");
    end
    for (int i = 0; i < 3; i++) idle(32'h0, "drain");

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: actual %0d left required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
